// File: rtl/vscale_csr_arbiter_pkg.sv
// Shared CSR control constants: port widths, CSR command codes, arbiter FSM encoding
// and the latched host request payload.
package vscale_csr_arbiter_pkg;

   localparam int unsigned CSR_ADDR_WIDTH = 12;
   localparam int unsigned XPR_LEN        = 32;
   localparam int unsigned HTIF_PCR_WIDTH = 64;
   localparam int unsigned CSR_CMD_WIDTH  = 3;

   localparam logic [CSR_CMD_WIDTH-1:0] CSR_IDLE  = 3'd0;
   localparam logic [CSR_CMD_WIDTH-1:0] CSR_READ  = 3'd4;
   localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE = 3'd5;
   localparam logic [CSR_CMD_WIDTH-1:0] CSR_SET   = 3'd6;
   localparam logic [CSR_CMD_WIDTH-1:0] CSR_CLEAR = 3'd7;

   localparam int unsigned STARVE_LIMIT_DEFAULT = 8;
   localparam int unsigned CNT_W_DEFAULT        = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_PEND = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic                      rw;
      logic [CSR_ADDR_WIDTH-1:0] addr;
      logic [XPR_LEN-1:0]        data;
   } host_req_t;

endpackage

// File: rtl/vscale_csr_arbiter.sv
// Shares the CSR-file port between core CSR instructions and one latched host PCR request,
// forcing a one-cycle core stall if the host has waited STARVE_LIMIT cycles.
module vscale_csr_arbiter
   import vscale_csr_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
   parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CSR_ADDR_WIDTH-1:0] core_csr_addr,
   input  logic [CSR_CMD_WIDTH-1:0]  core_csr_cmd,
   input  logic [XPR_LEN-1:0]        core_csr_wdata,
   output logic                      core_stall,
   input  logic                      htif_pcr_req_valid,
   output logic                      htif_pcr_req_ready,
   input  logic                      htif_pcr_req_rw,
   input  logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
   input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
   output logic                      htif_pcr_resp_valid,
   input  logic                      htif_pcr_resp_ready,
   output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
   output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
   output logic [CSR_CMD_WIDTH-1:0]  csr_cmd,
   output logic [XPR_LEN-1:0]        csr_wdata,
   input  logic [XPR_LEN-1:0]        csr_rdata
);

   arb_state_e         state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   host_req_t          req, req_nxt;
   logic [XPR_LEN-1:0] resp, resp_nxt;
   logic               starved;

   // Only the low word of host write data reaches the CSR file.
   logic unused_req_data_hi;
   assign unused_req_data_hi = ^htif_pcr_req_data[HTIF_PCR_WIDTH-1:XPR_LEN];

   assign starved            = (cnt == CNT_W'(STARVE_LIMIT));
   assign htif_pcr_resp_data = HTIF_PCR_WIDTH'(resp);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ARB_IDLE;
         cnt   <= '0;
         req   <= '0;
         resp  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         req   <= req_nxt;
         resp  <= resp_nxt;
      end
   end

   always_comb begin
      state_nxt           = state;
      cnt_nxt             = cnt;
      req_nxt             = req;
      resp_nxt            = resp;
      htif_pcr_req_ready  = 1'b0;
      htif_pcr_resp_valid = 1'b0;
      core_stall          = 1'b0;
      csr_addr            = core_csr_addr;
      csr_cmd             = core_csr_cmd;
      csr_wdata           = core_csr_wdata;

      case (state)
         ARB_IDLE: begin
            htif_pcr_req_ready = 1'b1;
            if (htif_pcr_req_valid) begin
               req_nxt.rw   = htif_pcr_req_rw;
               req_nxt.addr = htif_pcr_req_addr;
               req_nxt.data = htif_pcr_req_data[XPR_LEN-1:0];
               cnt_nxt      = '0;
               state_nxt    = ARB_PEND;
            end
         end
         ARB_PEND: begin
            // Grant when the core is idle, or steal the port once the wait budget is spent.
            if (core_csr_cmd == CSR_IDLE || starved) begin
               core_stall = (core_csr_cmd != CSR_IDLE);
               csr_addr   = req.addr;
               csr_cmd    = req.rw ? CSR_WRITE : CSR_READ;
               csr_wdata  = req.data;
               resp_nxt   = csr_rdata;
               state_nxt  = ARB_RESP;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ARB_RESP: begin
            htif_pcr_resp_valid = 1'b1;
            if (htif_pcr_resp_ready) begin
               state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_vscale_csr_arbiter.sv
// Directed bench for vscale_csr_arbiter with a tiny CSR-file model on the shared port.
module tb_vscale_csr_arbiter;
   import vscale_csr_arbiter_pkg::*;

   logic                      clk = 1'b0;
   logic                      reset_n;
   logic [CSR_ADDR_WIDTH-1:0] core_csr_addr;
   logic [CSR_CMD_WIDTH-1:0]  core_csr_cmd;
   logic [XPR_LEN-1:0]        core_csr_wdata;
   logic                      core_stall;
   logic                      htif_pcr_req_valid;
   logic                      htif_pcr_req_ready;
   logic                      htif_pcr_req_rw;
   logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr;
   logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data;
   logic                      htif_pcr_resp_valid;
   logic                      htif_pcr_resp_ready;
   logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data;
   logic [CSR_ADDR_WIDTH-1:0] csr_addr;
   logic [CSR_CMD_WIDTH-1:0]  csr_cmd;
   logic [XPR_LEN-1:0]        csr_wdata;
   logic [XPR_LEN-1:0]        csr_rdata;

   int checks = 0;
   int errors = 0;

   logic [XPR_LEN-1:0] r781 = 32'h5555_AAAA;

   always #5 clk = ~clk;

   vscale_csr_arbiter dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .core_csr_addr       (core_csr_addr),
      .core_csr_cmd        (core_csr_cmd),
      .core_csr_wdata      (core_csr_wdata),
      .core_stall          (core_stall),
      .htif_pcr_req_valid  (htif_pcr_req_valid),
      .htif_pcr_req_ready  (htif_pcr_req_ready),
      .htif_pcr_req_rw     (htif_pcr_req_rw),
      .htif_pcr_req_addr   (htif_pcr_req_addr),
      .htif_pcr_req_data   (htif_pcr_req_data),
      .htif_pcr_resp_valid (htif_pcr_resp_valid),
      .htif_pcr_resp_ready (htif_pcr_resp_ready),
      .htif_pcr_resp_data  (htif_pcr_resp_data),
      .csr_addr            (csr_addr),
      .csr_cmd             (csr_cmd),
      .csr_wdata           (csr_wdata),
      .csr_rdata           (csr_rdata)
   );

   // CSR file model: 0x780 fixed, 0x781 writable, others read back their address.
   always_comb begin
      case (csr_addr)
         12'h780: csr_rdata = 32'h0000_1234;
         12'h781: csr_rdata = r781;
         default: csr_rdata = XPR_LEN'(csr_addr);
      endcase
   end

   always @(posedge clk) begin
      if (csr_cmd == CSR_WRITE && csr_addr == 12'h781) r781 <= csr_wdata;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock, leave time for combinational outputs to settle after new drives.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic host_req(input logic rw, input logic [11:0] addr, input logic [63:0] data);
      htif_pcr_req_valid = 1'b1;
      htif_pcr_req_rw    = rw;
      htif_pcr_req_addr  = addr;
      htif_pcr_req_data  = data;
   endtask

   task automatic core_op(input logic [2:0] cmd, input logic [11:0] addr);
      core_csr_cmd   = cmd;
      core_csr_addr  = addr;
      core_csr_wdata = 32'h0000_0001;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n             = 1'b0;
      htif_pcr_req_valid  = 1'b0;
      htif_pcr_req_rw     = 1'b0;
      htif_pcr_req_addr   = '0;
      htif_pcr_req_data   = '0;
      htif_pcr_resp_ready = 1'b0;
      core_op(CSR_READ, 12'h300);
      cyc();
      cyc();
      #1;
      check("rst_req_ready", 64'(htif_pcr_req_ready), 64'd1);
      check("rst_resp_valid", 64'(htif_pcr_resp_valid), 64'd0);
      check("rst_resp_data", htif_pcr_resp_data, 64'd0);
      check("rst_stall", 64'(core_stall), 64'd0);
      check("rst_pass_addr", 64'(csr_addr), 64'h300);
      check("rst_pass_cmd", 64'(csr_cmd), 64'(CSR_READ));
      reset_n = 1'b1;

      // 1: host read, core idle
      core_op(CSR_IDLE, 12'h000);
      host_req(1'b0, 12'h780, 64'h0);
      #1;
      check("t1_accept_ready", 64'(htif_pcr_req_ready), 64'd1);
      check("t1_accept_nogrant", 64'(csr_cmd), 64'(CSR_IDLE));
      cyc();
      htif_pcr_req_valid = 1'b0;
      #1;
      check("t1_pend_ready", 64'(htif_pcr_req_ready), 64'd0);
      check("t1_grant_addr", 64'(csr_addr), 64'h780);
      check("t1_grant_cmd", 64'(csr_cmd), 64'(CSR_READ));
      check("t1_grant_stall", 64'(core_stall), 64'd0);
      check("t1_grant_nvalid", 64'(htif_pcr_resp_valid), 64'd0);
      cyc();
      check("t1_resp_valid", 64'(htif_pcr_resp_valid), 64'd1);
      check("t1_resp_data", htif_pcr_resp_data, 64'h0000_0000_0000_1234);
      check("t1_resp_stall", 64'(core_stall), 64'd0);
      htif_pcr_resp_ready = 1'b1;
      cyc();
      htif_pcr_resp_ready = 1'b0;
      #1;
      check("t1_idle_valid", 64'(htif_pcr_resp_valid), 64'd0);
      check("t1_idle_ready", 64'(htif_pcr_req_ready), 64'd1);

      // 2: host write returns the old value; read-back sees the new one
      host_req(1'b1, 12'h781, 64'hFFFF_0000_DEAD_BEEF);
      cyc();
      htif_pcr_req_valid = 1'b0;
      #1;
      check("t2_grant_cmd", 64'(csr_cmd), 64'(CSR_WRITE));
      check("t2_grant_addr", 64'(csr_addr), 64'h781);
      check("t2_grant_wdata", 64'(csr_wdata), 64'hDEAD_BEEF);
      cyc();
      check("t2_resp_old", htif_pcr_resp_data, 64'h0000_0000_5555_AAAA);
      htif_pcr_resp_ready = 1'b1;
      cyc();
      htif_pcr_resp_ready = 1'b0;
      host_req(1'b0, 12'h781, 64'h0);
      cyc();
      htif_pcr_req_valid = 1'b0;
      cyc();
      check("t2_readback", htif_pcr_resp_data, 64'h0000_0000_DEAD_BEEF);
      htif_pcr_resp_ready = 1'b1;
      cyc();
      htif_pcr_resp_ready = 1'b0;

      // 3: core busy every cycle -> forced grant after 8 wait cycles
      core_op(CSR_SET, 12'h300);
      host_req(1'b0, 12'h780, 64'h0);
      cyc();
      htif_pcr_req_valid = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t3_wait%0d_stall", i), 64'(core_stall), 64'd0);
         check($sformatf("t3_wait%0d_cmd", i), 64'(csr_cmd), 64'(CSR_SET));
         cyc();
      end
      check("t3_force_stall", 64'(core_stall), 64'd1);
      check("t3_force_cmd", 64'(csr_cmd), 64'(CSR_READ));
      check("t3_force_addr", 64'(csr_addr), 64'h780);
      cyc();
      check("t3_resp_stall", 64'(core_stall), 64'd0);
      check("t3_resp_pass", 64'(csr_cmd), 64'(CSR_SET));
      check("t3_resp_data", htif_pcr_resp_data, 64'h1234);
      htif_pcr_resp_ready = 1'b1;
      cyc();
      htif_pcr_resp_ready = 1'b0;
      core_op(CSR_IDLE, 12'h000);

      // 4: response back-pressure, new request waits until IDLE
      host_req(1'b0, 12'h782, 64'h0);
      cyc();
      htif_pcr_req_valid = 1'b0;
      cyc();
      host_req(1'b0, 12'h783, 64'h0);
      #1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t4_hold%0d_valid", i), 64'(htif_pcr_resp_valid), 64'd1);
         check($sformatf("t4_hold%0d_data", i), htif_pcr_resp_data, 64'h782);
         check($sformatf("t4_hold%0d_ready", i), 64'(htif_pcr_req_ready), 64'd0);
         cyc();
      end
      htif_pcr_resp_ready = 1'b1;
      cyc();
      htif_pcr_resp_ready = 1'b0;
      #1;
      check("t4_idle_valid", 64'(htif_pcr_resp_valid), 64'd0);
      check("t4_idle_ready", 64'(htif_pcr_req_ready), 64'd1);
      cyc();
      htif_pcr_req_valid = 1'b0;
      #1;
      check("t4_new_grant_addr", 64'(csr_addr), 64'h783);
      cyc();
      check("t4_new_resp", htif_pcr_resp_data, 64'h783);
      htif_pcr_resp_ready = 1'b1;
      cyc();
      htif_pcr_resp_ready = 1'b0;

      // 5: reset while pending drops the request
      core_op(CSR_CLEAR, 12'h305);
      host_req(1'b0, 12'h780, 64'h0);
      cyc();
      htif_pcr_req_valid = 1'b0;
      #1;
      check("t5_pend_ready", 64'(htif_pcr_req_ready), 64'd0);
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      core_op(CSR_READ, 12'h301);
      #1;
      check("t5_rst_ready", 64'(htif_pcr_req_ready), 64'd1);
      check("t5_rst_valid", 64'(htif_pcr_resp_valid), 64'd0);
      check("t5_rst_pass_cmd", 64'(csr_cmd), 64'(CSR_READ));
      check("t5_rst_pass_addr", 64'(csr_addr), 64'h301);
      check("t5_rst_stall", 64'(core_stall), 64'd0);
      core_op(CSR_IDLE, 12'h000);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t5_after%0d_nogrant", i), 64'(csr_cmd), 64'(CSR_IDLE));
         check($sformatf("t5_after%0d_nvalid", i), 64'(htif_pcr_resp_valid), 64'd0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
